chn_filtr_multi: RTL
====================

Name: chn_filtr_multi

Overview:
Parametrised multi-channel digital debounce/glitch filter for encoder inputs (A, B, Z by default).
- Each channel is synchronised, then qualified by a run-length counter against a runtime threshold.
- Outputs per channel: filtered level plus one-cycle rise/fall strobes.
- A shared saturating counter reports rejected glitches.
- Sits between the encoder pins and the quadrature decoder / position counter.

Parameters:
N_CH, 3, number of filtered channels
CNT_W, 8, width of the per-channel run counter and of the threshold input
SYNC_STAGES, 2, input synchroniser depth (legal range 2..4)
GLITCH_W, 16, width of the shared glitch counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
chn_in  in  N_CH  raw channel inputs, asynchronous to clk
thr  in  CNT_W  filter threshold in clk cycles, sampled every cycle
en  in  1  filter enable
glitch_clr  in  1  synchronous clear of glitch_cnt
chn_out  out  N_CH  filtered channel levels
rise  out  N_CH  one-cycle strobe when chn_out[i] goes 0->1
fall  out  N_CH  one-cycle strobe when chn_out[i] goes 1->0
glitch_cnt  out  GLITCH_W  saturating count of rejected pulses, all channels

Behaviour:
- Reset (rst_n=0, asynchronous): synchroniser flops, run counters, chn_out, rise, fall and glitch_cnt all go to 0. Deassertion is taken synchronously by the integrating logic.
- Synchroniser: sync[i] is chn_in[i] delayed by SYNC_STAGES flops. No filtering happens before the last stage.
- Per channel, each cycle with en=1, define diff = (sync[i] != chn_out[i]):
  - diff=1 and cnt+1 < eff_thr: cnt <= cnt+1.
  - diff=1 and cnt+1 >= eff_thr: chn_out[i] toggles, cnt <= 0, and rise[i] or fall[i] pulses in the same cycle as the new chn_out value.
  - diff=0 and cnt!=0: cnt <= 0; counts as one rejected glitch.
  - diff=0 and cnt==0: hold.
- eff_thr = max(thr, 1). thr=0 and thr=1 both give a 1-cycle qualify time.
- Latency: a clean edge on sync[i] appears on chn_out[i] exactly eff_thr cycles later. Total pin-to-output latency is SYNC_STAGES + eff_thr cycles.
- cnt never exceeds eff_thr-1 and needs no saturation logic. Compare in CNT_W+1 bits so thr = 2^CNT_W-1 works without wrap.
- thr changed mid-run: the new value applies the same cycle. If the accumulated cnt+1 already reaches the new eff_thr while diff=1, the toggle happens on that edge.
- en=0:
  - All run counters are cleared and chn_out holds.
  - rise and fall stay 0 and no glitches are counted.
  - The synchronisers keep running.
  - On re-enable, qualification starts from cnt=0.
- rise/fall are mutually exclusive per channel and never assert two consecutive cycles for the same channel when eff_thr >= 2.
- Glitch counter:
  - Each cycle, inc = number of channels rejecting a glitch (0..N_CH).
  - glitch_cnt <= min(glitch_cnt + inc, 2^GLITCH_W - 1).
  - glitch_clr=1 forces 0 and takes priority over inc in the same cycle; glitches occurring in that cycle are dropped.
- Channels are fully independent. Simultaneous toggles on several channels are legal and produce simultaneous strobes.
- Reset asserted mid-qualification: the pending edge is lost and chn_out returns to 0. A channel whose input is high after reset re-qualifies in SYNC_STAGES + eff_thr cycles and produces a rise strobe.

Test Plan:
- Reset with chn_in=3'b111, thr=80, release rst_n -> chn_out stays 0 for 81 cycles (2 sync + 79), goes 3'b111 at cycle 82 after release; rise=3'b111 for exactly 1 cycle, glitch_cnt=0.
- thr=10, 9-cycle high pulse on ch0 -> chn_out[0] stays 0, glitch_cnt=1. Then a 10-cycle pulse -> chn_out[0] rises 12 cycles after the pin edge with 1-cycle rise[0], and falls 12 cycles after the pin falling edge with 1-cycle fall[0].
- thr=0 and thr=1, toggle ch1 every 4 cycles -> chn_out[1] follows with 3-cycle latency (2 sync + 1), strobes on every transition, glitch_cnt unchanged.
- thr=50, ch2 held high 30 cycles, thr dropped to 20 -> chn_out[2] toggles on the same edge thr changes; fall back after 20 cycles once ch2 drops.
- GLITCH_W=4, inject 1-cycle glitches on all 3 channels simultaneously 6 times -> glitch_cnt 3, 6, 9, 12, 15, 15 (saturated). Then glitch_clr=1 in a cycle with another glitch -> glitch_cnt=0.
- thr=8, ch0 high 5 cycles then en=0 for 3 cycles then en=1 -> no toggle during en=0, no glitch counted; chn_out[0] rises 8 cycles after en returns.

Source files
------------

// File: rtl/chn_filtr_multi.sv
// Multi-channel debounce/glitch filter: synchronise each input, then accept a level change only
// after it has held for thr cycles; rejected short pulses are tallied in a shared counter.
module chn_filtr_multi #(
    parameter int N_CH        = 3,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int GLITCH_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CH-1:0]     chn_in,
    input  logic [CNT_W-1:0]    thr,
    input  logic                en,
    input  logic                glitch_clr,
    output logic [N_CH-1:0]     chn_out,
    output logic [N_CH-1:0]     rise,
    output logic [N_CH-1:0]     fall,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam logic [GLITCH_W-1:0] G_MAX = '1;

    function automatic logic [GLITCH_W-1:0] sat_glitch(input logic [GLITCH_W:0] v);
        return (v > {1'b0, G_MAX}) ? G_MAX : v[GLITCH_W-1:0];
    endfunction

    logic [N_CH-1:0]  sync_q [SYNC_STAGES];
    logic [N_CH-1:0]  sync;
    logic [CNT_W-1:0] cnt     [N_CH];
    logic [CNT_W-1:0] cnt_nxt [N_CH];
    logic [CNT_W:0]   eff_thr;
    logic [N_CH-1:0]  tog;
    logic [N_CH-1:0]  rej;
    logic [GLITCH_W:0] glitch_sum;

    // One extra bit so thr = 2^CNT_W-1 compares against cnt+1 without wrapping
    assign eff_thr = (thr == '0) ? (CNT_W + 1)'(1) : {1'b0, thr};
    assign sync    = sync_q[SYNC_STAGES-1];

    // Synchroniser stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= chn_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    always_comb begin
        tog = '0;
        rej = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_nxt[i] = '0;
            if (en) begin
                if (sync[i] != chn_out[i]) begin
                    if (({1'b0, cnt[i]} + (CNT_W + 1)'(1)) >= eff_thr) tog[i] = 1'b1;
                    else cnt_nxt[i] = cnt[i] + 1'b1;
                end else if (cnt[i] != '0) begin
                    rej[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        glitch_sum = {1'b0, glitch_cnt};
        for (int i = 0; i < N_CH; i++) glitch_sum = glitch_sum + (GLITCH_W + 1)'(rej[i]);
    end

    // Qualification and output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
            chn_out    <= '0;
            rise       <= '0;
            fall       <= '0;
            glitch_cnt <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) cnt[i] <= cnt_nxt[i];
            chn_out    <= chn_out ^ tog;
            rise       <= tog & ~chn_out;
            fall       <= tog & chn_out;
            glitch_cnt <= glitch_clr ? '0 : sat_glitch(glitch_sum);
        end
    end

endmodule
